// File: rtl/uart_rx_controller.sv
// Receive sequencer for the SingleCycle UART: synchronizes rxd, samples mid-bit on an
// oversampled tick, assembles LSB-first and pushes to the RX FIFO. Optional parity: UART_RX_PARITY_EN.
module uart_rx_controller #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic                 rxd,
   input  logic                 rx_fifo_full,
   output logic                 rx_push,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 framing_err,
   output logic                 overrun_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Nonzero when data, received parity bit and the configured sense disagree.
   function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic pbit);
      return (^data) ^ pbit ^ PARITY_ODD;
   endfunction

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 push_q, push_d;
   logic                 fe_q, fe_d;
   logic                 oe_q, oe_d;
   logic                 pe_q, pe_d;
   logic                 par_q, par_d;
   logic                 busy_q, busy_d;
   logic                 sync1_q, sync2_q, prev_q;
   logic                 fall_s;

   assign fall_s = prev_q & ~sync2_q;

   // Input synchronizer plus previous-value flop for falling-edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= rxd;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Next-state, counter and result logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      par_d     = par_q;
      push_d    = 1'b0;
      fe_d      = 1'b0;
      oe_d      = 1'b0;
      pe_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fall_s) begin
               state_d = S_START;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = '0;
            end
         end
         S_START: begin
            if (baud_tick) begin
               if (cnt_q == CNT_HALF) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = sync2_q ? S_IDLE : S_DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_DATA: begin
            if (baud_tick) begin
               if (cnt_q == CNT_FULL) begin
                  cnt_d   = '0;
                  idx_d   = idx_q + 1'b1;
                  shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                  if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_d = S_PARITY;
`else
                     state_d = S_STOP;
`endif
                  end else begin
                     state_d = S_DATA;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (baud_tick) begin
               if (cnt_q == CNT_FULL) begin
                  cnt_d   = '0;
                  par_d   = sync2_q;
                  state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
`endif
         S_STOP: begin
            if (baud_tick) begin
               if (cnt_q == CNT_FULL) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  if (sync2_q && !rx_fifo_full) begin
                     push_d    = 1'b1;
                     rx_data_d = shift_q;
                  end else if (sync2_q) begin
                     oe_d = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
`ifdef UART_RX_PARITY_EN
                  pe_d = parity_bad(shift_q, par_q);
`endif
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         par_q     <= 1'b0;
         push_q    <= 1'b0;
         fe_q      <= 1'b0;
         oe_q      <= 1'b0;
         pe_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         par_q     <= par_d;
         push_q    <= push_d;
         fe_q      <= fe_d;
         oe_q      <= oe_d;
         pe_q      <= pe_d;
         busy_q    <= busy_d;
      end
   end

   assign rx_push     = push_q;
   assign rx_data     = rx_data_q;
   assign framing_err = fe_q;
   assign overrun_err = oe_q;
   assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err  = pe_q;
`else
   assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: 8 data bits, 16x oversampling, baud_tick every 4 clk.
module tb_uart_rx_controller;

   localparam int BIT_CLKS = 64;

   logic       clk;
   logic       reset_n;
   logic       baud_tick;
   logic       rxd;
   logic       rx_fifo_full;
   logic       rx_push;
   logic [7:0] rx_data;
   logic       framing_err;
   logic       overrun_err;
   logic       parity_err;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int push_cnt = 0;
   int fe_cnt   = 0;
   int oe_cnt   = 0;
   int pe_cnt   = 0;
   logic [7:0] last_data = 8'h00;

   uart_rx_controller #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rxd(rxd),
      .rx_fifo_full(rx_fifo_full), .rx_push(rx_push), .rx_data(rx_data),
      .framing_err(framing_err), .overrun_err(overrun_err), .parity_err(parity_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_push) begin
         push_cnt++;
         last_data = rx_data;
      end
      if (framing_err) fe_cnt++;
      if (overrun_err) oe_cnt++;
      if (parity_err) pe_cnt++;
   end

   task automatic clear_counts();
      push_cnt = 0;
      fe_cnt   = 0;
      oe_cnt   = 0;
      pe_cnt   = 0;
   endtask

   task automatic bit_period(input logic v);
      rxd = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
      bit_period(1'b0);
      for (int i = 0; i < 8; i++) bit_period(d[i]);
`ifdef UART_RX_PARITY_EN
      bit_period(pbit);
`else
      if (pbit === 1'bx) rxd = 1'b1;
`endif
      bit_period(stopb);
   endtask

   task automatic check_counts(input string tag, input int ep, input int ef, input int eo);
      n_checks++;
      if (push_cnt !== ep) begin n_fail++; $display("FAIL %s push_count got %0d exp %0d", tag, push_cnt, ep); end
      n_checks++;
      if (fe_cnt !== ef) begin n_fail++; $display("FAIL %s framing_count got %0d exp %0d", tag, fe_cnt, ef); end
      n_checks++;
      if (oe_cnt !== eo) begin n_fail++; $display("FAIL %s overrun_count got %0d exp %0d", tag, oe_cnt, eo); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rxd = 1'b1;
      rx_fifo_full = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({rx_push, framing_err, overrun_err, parity_err, busy} !== 5'b00000) begin
         n_fail++;
         $display("FAIL reset_flags got %b exp 00000", {rx_push, framing_err, overrun_err, parity_err, busy});
      end
      n_checks++;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", rx_data); end
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
      check_counts("reset", 0, 0, 0);
   endtask

   task automatic test_frame_55();
      clear_counts();
      send_frame(8'h55, ^8'h55, 1'b1);
      bit_period(1'b1);
      check_counts("frame55", 1, 0, 0);
      n_checks++;
      if (last_data !== 8'h55) begin n_fail++; $display("FAIL frame55_data got %h exp 55", last_data); end
      n_checks++;
      if (rx_data !== 8'h55) begin n_fail++; $display("FAIL frame55_hold got %h exp 55", rx_data); end
      n_checks++;
      if (pe_cnt !== 0) begin n_fail++; $display("FAIL frame55_parity got %0d exp 0", pe_cnt); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL frame55_busy got %b exp 0", busy); end
   endtask

   task automatic test_false_start();
      clear_counts();
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_hi got %b exp 1", busy); end
      repeat (8) @(negedge clk);
      rxd = 1'b1;
      repeat (100) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_lo got %b exp 0", busy); end
      check_counts("false_start", 0, 0, 0);
   endtask

   task automatic test_framing_break();
      clear_counts();
      send_frame(8'hA3, ^8'hA3, 1'b0);
      repeat (3 * BIT_CLKS) @(negedge clk);
      check_counts("framing", 0, 1, 0);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy got %b exp 0", busy); end
      bit_period(1'b1);
      send_frame(8'h5A, ^8'h5A, 1'b1);
      bit_period(1'b1);
      check_counts("after_break", 1, 1, 0);
      n_checks++;
      if (last_data !== 8'h5A) begin n_fail++; $display("FAIL after_break_data got %h exp 5a", last_data); end
   endtask

   task automatic test_overrun();
      clear_counts();
      rx_fifo_full = 1'b1;
      send_frame(8'h3C, ^8'h3C, 1'b1);
      rx_fifo_full = 1'b0;
      bit_period(1'b1);
      check_counts("overrun", 0, 0, 1);
      n_checks++;
      if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL overrun_hold got %h exp 5a", rx_data); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      clear_counts();
      d = 8'h81;
      bit_period(1'b0);
      for (int i = 0; i < 4; i++) bit_period(d[i]);
      rxd = d[4];
      repeat (32) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before got %b exp 1", busy); end
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b exp 0", busy); end
      rxd = 1'b1;
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      check_counts("midreset", 0, 0, 0);
      n_checks++;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset_data got %h exp 00", rx_data); end
      send_frame(8'h81, ^8'h81, 1'b1);
      bit_period(1'b1);
      check_counts("post_reset", 1, 0, 0);
      n_checks++;
      if (last_data !== 8'h81) begin n_fail++; $display("FAIL post_reset_data got %h exp 81", last_data); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      clear_counts();
      send_frame(8'h07, 1'b1, 1'b1);
      bit_period(1'b1);
      check_counts("parity_good", 1, 0, 0);
      n_checks++;
      if (pe_cnt !== 0) begin n_fail++; $display("FAIL parity_good_err got %0d exp 0", pe_cnt); end
      n_checks++;
      if (last_data !== 8'h07) begin n_fail++; $display("FAIL parity_good_data got %h exp 07", last_data); end
      send_frame(8'h07, 1'b0, 1'b1);
      bit_period(1'b1);
      check_counts("parity_bad", 2, 0, 0);
      n_checks++;
      if (pe_cnt !== 1) begin n_fail++; $display("FAIL parity_bad_err got %0d exp 1", pe_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_frame_55();
      test_false_start();
      test_framing_break();
      test_overrun();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
